v2f_op_scheduler: RTL and testbench

// Time-shares one 32-bit arithmetic combinator between N requesters. It is the

---
 rtl/v2f_op_scheduler.sv | 273 +++++++++++++++++++++++++++
 tb/tb_v2f_op_scheduler.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/v2f_op_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : v2f_op_scheduler                                             |
// | Description : Shares one 32-bit arithmetic combinator among N_REQ          |
// |               requesters. A round-robin arbiter grants at most one request |
// |               per cycle. The granted operation enters a fixed-latency      |
// |               pipeline, and each result returns tagged with the ID of the  |
// |               requester that issued it.                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Parameters                                                                 |
// |   N_REQ     number of requesters (2..16)                                   |
// |   LATENCY   cycles from request handshake to rsp_valid (1..8)              |
// |   ID_W      width of rsp_id, $clog2(N_REQ)                                 |
// | Ports                                                                      |
// |   clk        in   1          clock; all state updates on the rising edge   |
// |   srst       in   1          synchronous reset, active-high                |
// |   hold       in   1          1 = no new grants; in-flight ops still drain  |
// |   req_valid  in   N_REQ      per-requester request valid                   |
// |   req_ready  out  N_REQ      one-hot or zero grant (combinational)         |
// |   req_op     in   3*N_REQ    opcode, slice i = [3i+2:3i]                   |
// |   req_a      in   32*N_REQ   operand A (signed), slice i = [32i+31:32i]    |
// |   req_b      in   32*N_REQ   operand B (signed), slice i = [32i+31:32i]    |
// |   rsp_valid  out  1          one-cycle pulse per completed operation       |
// |   rsp_id     out  ID_W       requester index of the completed operation    |
// |   rsp_y      out  32         result (signed)                               |
// |   busy       out  1          any pipeline stage holds a valid operation    |
// | Opcodes: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD, 5 AND, 6 OR, 7 XOR             |
// +----------------------------------------------------------------------------+
module v2f_op_scheduler #(
   parameter  int N_REQ   = 4,
   parameter  int LATENCY = 2,
   localparam int ID_W    = $clog2(N_REQ)
) (
   input  logic                  clk,
   input  logic                  srst,
   input  logic                  hold,
   input  logic [N_REQ-1:0]      req_valid,
   output logic [N_REQ-1:0]      req_ready,
   input  logic [3*N_REQ-1:0]    req_op,
   input  logic [32*N_REQ-1:0]   req_a,
   input  logic [32*N_REQ-1:0]   req_b,
   output logic                  rsp_valid,
   output logic [ID_W-1:0]       rsp_id,
   output logic [31:0]           rsp_y,
   output logic                  busy
);

   localparam logic [2:0] c_op_add = 3'd0;
   localparam logic [2:0] c_op_sub = 3'd1;
   localparam logic [2:0] c_op_mul = 3'd2;
   localparam logic [2:0] c_op_div = 3'd3;
   localparam logic [2:0] c_op_mod = 3'd4;
   localparam logic [2:0] c_op_and = 3'd5;
   localparam logic [2:0] c_op_or  = 3'd6;
   localparam logic [2:0] c_op_xor = 3'd7;

   localparam logic [ID_W-1:0] c_ptr_rst = ID_W'(N_REQ - 1);

   // -------------------------------------------------------------------------
   // Round-robin arbiter
   // -------------------------------------------------------------------------
   logic [ID_W-1:0]  ptr_q, ptr_d;
   logic [ID_W:0]    w_shamt;
   logic [ID_W:0]    w_sum;
   logic [N_REQ-1:0] w_rot;
   logic             w_found;
   logic             w_grant;
   logic [ID_W-1:0]  w_grant_id;
   logic [N_REQ-1:0] w_grant_vec;

   // The doubled request vector shifted right by pointer+1 puts the
   // highest-priority requester at bit 0, so a plain find-first over w_rot
   // gives the round-robin winner. The winning index is then recovered as
   // (pointer + 1 + k) mod N_REQ; the sum never exceeds 2*N_REQ-1, so a
   // single conditional subtraction is enough for any N_REQ.
   always_comb begin
      w_shamt    = {1'b0, ptr_q} + (ID_W+1)'(1);
      w_rot      = N_REQ'({req_valid, req_valid} >> w_shamt);
      w_found    = 1'b0;
      w_sum      = '0;
      w_grant_id = ptr_q;
      for (int k = 0; k < N_REQ; k++) begin
         if (!w_found && w_rot[k]) begin
            w_found = 1'b1;
            w_sum   = w_shamt + (ID_W+1)'(k);
         end
      end
      if (w_sum >= (ID_W+1)'(N_REQ)) begin
         w_sum = w_sum - (ID_W+1)'(N_REQ);
      end
      if (w_found) begin
         w_grant_id = w_sum[ID_W-1:0];
      end
      // Reset also masks the grant so nothing is accepted in a reset cycle.
      w_grant     = w_found && !hold && !srst;
      w_grant_vec = w_grant ? (N_REQ'(1) << w_grant_id) : '0;
   end

   assign req_ready = w_grant_vec;

   always_comb begin
      ptr_d = ptr_q;
      if (w_grant) begin
         ptr_d = w_grant_id;
      end
   end

   // Operand mux: w_grant_vec is one-hot, so at most one slice is selected.
   logic [2:0]  w_sel_op;
   logic [31:0] w_sel_a;
   logic [31:0] w_sel_b;

   always_comb begin
      w_sel_op = '0;
      w_sel_a  = '0;
      w_sel_b  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_grant_vec[i]) begin
            w_sel_op = req_op[3*i +: 3];
            w_sel_a  = req_a[32*i +: 32];
            w_sel_b  = req_b[32*i +: 32];
         end
      end
   end

   // -------------------------------------------------------------------------
   // Stage 0: registered request. Payload only loads on a grant, so with
   // LATENCY=1 the outputs naturally hold their last value between pulses.
   // -------------------------------------------------------------------------
   logic            s0_valid_q, s0_valid_d;
   logic [ID_W-1:0] s0_id_q,    s0_id_d;
   logic [2:0]      s0_op_q,    s0_op_d;
   logic [31:0]     s0_a_q,     s0_a_d;
   logic [31:0]     s0_b_q,     s0_b_d;

   always_comb begin
      s0_valid_d = w_grant;
      s0_id_d    = s0_id_q;
      s0_op_d    = s0_op_q;
      s0_a_d     = s0_a_q;
      s0_b_d     = s0_b_q;
      if (w_grant) begin
         s0_id_d = w_grant_id;
         s0_op_d = w_sel_op;
         s0_a_d  = w_sel_a;
         s0_b_d  = w_sel_b;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         ptr_q      <= c_ptr_rst;
         s0_valid_q <= 1'b0;
         s0_id_q    <= '0;
         s0_op_q    <= '0;
         s0_a_q     <= '0;
         s0_b_q     <= '0;
      end else begin
         ptr_q      <= ptr_d;
         s0_valid_q <= s0_valid_d;
         s0_id_q    <= s0_id_d;
         s0_op_q    <= s0_op_d;
         s0_a_q     <= s0_a_d;
         s0_b_q     <= s0_b_d;
      end
   end

   // -------------------------------------------------------------------------
   // Combinator, evaluated from stage 0
   // -------------------------------------------------------------------------
   logic signed [31:0] w_a;
   logic signed [31:0] w_b;
   logic signed [31:0] w_y;

   assign w_a = s0_a_q;
   assign w_b = s0_b_q;

   // B = -1 is special-cased for DIV/MOD: -2^31 / -1 must wrap to -2^31
   // (which 0 - A does) and the remainder is always 0, which keeps the
   // overflowing divide case away from the generic divider.
   always_comb begin
      w_y = '0;
      case (s0_op_q)
         c_op_add: w_y = w_a + w_b;
         c_op_sub: w_y = w_a - w_b;
         c_op_mul: w_y = w_a * w_b;
         c_op_div: begin
            if (w_b == 32'sd0) begin
               w_y = '0;
            end else if (w_b == -32'sd1) begin
               w_y = 32'sd0 - w_a;
            end else begin
               w_y = w_a / w_b;
            end
         end
         c_op_mod: begin
            if (w_b == 32'sd0 || w_b == -32'sd1) begin
               w_y = '0;
            end else begin
               w_y = w_a % w_b;
            end
         end
         c_op_and: w_y = w_a & w_b;
         c_op_or:  w_y = w_a | w_b;
         c_op_xor: w_y = w_a ^ w_b;
         default:  w_y = '0;
      endcase
   end

   // -------------------------------------------------------------------------
   // Result delay line: stages 1..LATENCY-1 carry {valid, id, y}
   // -------------------------------------------------------------------------
   logic w_tail_busy;

   generate
      if (LATENCY == 1) begin : g_lat1
         assign rsp_valid   = s0_valid_q;
         assign rsp_id      = s0_id_q;
         assign rsp_y       = w_y;
         assign w_tail_busy = 1'b0;
      end else begin : g_latn
         logic [LATENCY-1:1] pv_q, pv_d;
         logic [ID_W-1:0]    pid_q [1:LATENCY-1];
         logic [ID_W-1:0]    pid_d [1:LATENCY-1];
         logic [31:0]        py_q  [1:LATENCY-1];
         logic [31:0]        py_d  [1:LATENCY-1];

         // Payload only advances alongside a valid bit, so the last stage
         // keeps the previous result visible while no pulse is present.
         always_comb begin
            pv_d  = pv_q;
            pid_d = pid_q;
            py_d  = py_q;
            pv_d[1] = s0_valid_q;
            if (s0_valid_q) begin
               pid_d[1] = s0_id_q;
               py_d[1]  = w_y;
            end
            for (int k = 2; k < LATENCY; k++) begin
               pv_d[k] = pv_q[k-1];
               if (pv_q[k-1]) begin
                  pid_d[k] = pid_q[k-1];
                  py_d[k]  = py_q[k-1];
               end
            end
         end

         always_ff @(posedge clk) begin
            if (srst) begin
               pv_q <= '0;
               for (int k = 1; k < LATENCY; k++) begin
                  pid_q[k] <= '0;
                  py_q[k]  <= '0;
               end
            end else begin
               pv_q  <= pv_d;
               pid_q <= pid_d;
               py_q  <= py_d;
            end
         end

         assign rsp_valid   = pv_q[LATENCY-1];
         assign rsp_id      = pid_q[LATENCY-1];
         assign rsp_y       = py_q[LATENCY-1];
         assign w_tail_busy = |pv_q;
      end
   endgenerate

   assign busy = s0_valid_q | w_tail_busy;

endmodule
`default_nettype wire

// File: tb/tb_v2f_op_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_v2f_op_scheduler                                          |
// | Description : Randomized scoreboard bench for v2f_op_scheduler. A request  |
// |               model predicts grants and pushes expected results; an output |
// |               monitor pops and compares them against the DUT.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_v2f_op_scheduler;

   localparam int N    = 4;
   localparam int LAT  = 2;
   localparam int NCYC = 1500;

   logic              clk = 1'b0;
   logic              srst;
   logic              hold;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ready;
   logic [3*N-1:0]    req_op;
   logic [32*N-1:0]   req_a;
   logic [32*N-1:0]   req_b;
   logic              rsp_valid;
   logic [1:0]        rsp_id;
   logic [31:0]       rsp_y;
   logic              busy;

   logic [2:0]  op_r [N];
   logic [31:0] a_r  [N];
   logic [31:0] b_r  [N];

   always_comb begin
      for (int i = 0; i < N; i++) begin
         req_op[3*i +: 3]  = op_r[i];
         req_a[32*i +: 32] = a_r[i];
         req_b[32*i +: 32] = b_r[i];
      end
   end

   v2f_op_scheduler #(.N_REQ(N), .LATENCY(LAT)) dut (
      .clk       (clk),
      .srst      (srst),
      .hold      (hold),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_y     (rsp_y),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit en    = 1'b0;
   bit acc [N];

   typedef struct {
      int          due;
      int          id;
      logic [31:0] y;
   } exp_t;

   exp_t sb [$];
   int   ptr_m = N - 1;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
      end
   endtask

   // Reference arithmetic in 64-bit signed, keeping the low 32 bits.
   function automatic logic [31:0] golden(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      longint sa;
      longint sbv;
      longint r;
      sa  = longint'(signed'(a));
      sbv = longint'(signed'(b));
      case (op)
         3'd0: r = sa + sbv;
         3'd1: r = sa - sbv;
         3'd2: r = sa * sbv;
         3'd3: r = (sbv == 0) ? 64'sd0 : sa / sbv;
         3'd4: r = (sbv == 0) ? 64'sd0 : sa % sbv;
         3'd5: r = longint'(a & b);
         3'd6: r = longint'(a | b);
         default: r = longint'(a ^ b);
      endcase
      return r[31:0];
   endfunction

   function automatic logic [31:0] rnd_opnd();
      case ($urandom_range(0, 11))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         4: return 32'd7;
         5: return 32'hFFFF_FFF9;
         6: return 32'd65536;
         7: return 32'd2;
         8: return 32'($urandom_range(0, 40));
         default: return $urandom;
      endcase
   endfunction

   task automatic new_req(input int i);
      op_r[i] = 3'($urandom_range(0, 7));
      a_r[i]  = rnd_opnd();
      b_r[i]  = rnd_opnd();
   endtask

   // Output monitor: busy, pulse timing, ID/result, and hold-last behaviour.
   initial begin
      bit          sp;
      int          lid;
      logic [31:0] ly;
      bit          exp_busy;
      exp_t        e;
      sp  = 1'b1;
      lid = 0;
      ly  = '0;
      forever begin
         @(negedge clk);
         if (en) begin
            if (sp) begin
               lid = 0;
               ly  = '0;
            end
            exp_busy = 1'b0;
            foreach (sb[k]) begin
               if (sb[k].due == cyc || sb[k].due == cyc + 1) exp_busy = 1'b1;
            end
            chk("busy", 64'(busy), 64'(exp_busy));
            while (sb.size() > 0 && sb[0].due < cyc) begin
               e = sb.pop_front();
               chk("missed_rsp", 64'(0), 64'(1));
            end
            if (sb.size() > 0 && sb[0].due == cyc) begin
               e = sb.pop_front();
               chk("rsp_valid", 64'(rsp_valid), 64'(1));
               chk("rsp_id", 64'(rsp_id), 64'(e.id));
               chk("rsp_y", 64'(rsp_y), 64'(e.y));
               lid = e.id;
               ly  = e.y;
            end else begin
               chk("rsp_idle", 64'(rsp_valid), 64'(0));
               chk("rsp_id_hold", 64'(rsp_id), 64'(lid));
               chk("rsp_y_hold", 64'(rsp_y), 64'(ly));
            end
            sp = srst;
         end
      end
   end

   // Request model: round-robin prediction, grant check, scoreboard push.
   initial begin
      int   gid;
      int   idx;
      exp_t keep [$];
      forever begin
         @(negedge clk);
         #1;
         if (en) begin
            gid = -1;
            if (!hold && !srst) begin
               for (int k = 1; k <= N; k++) begin
                  idx = (ptr_m + k) % N;
                  if (gid < 0 && req_valid[idx]) gid = idx;
               end
            end
            chk("req_ready", 64'(req_ready), (gid >= 0) ? (64'(1) << gid) : 64'(0));
            if (srst) begin
               keep.delete();
               foreach (sb[k]) if (sb[k].due <= cyc) keep.push_back(sb[k]);
               sb    = keep;
               ptr_m = N - 1;
            end else if (gid >= 0) begin
               sb.push_back('{cyc + LAT, gid, golden(op_r[gid], a_r[gid], b_r[gid])});
               ptr_m    = gid;
               acc[gid] = 1'b1;
            end
         end
      end
   end

   // Stimulus: phase 0 keeps every requester valid, phase 1 adds sparse
   // requests and HOLD, phase 2 also pulses SRST.
   initial begin
      int phase;
      srst      = 1'b1;
      hold      = 1'b0;
      req_valid = '1;
      for (int i = 0; i < N; i++) begin
         acc[i] = 1'b0;
         new_req(i);
      end
      @(posedge clk);
      #1;
      en = 1'b1;
      @(posedge clk);
      #1;
      for (int n = 0; n < NCYC; n++) begin
         phase = (n < 60) ? 0 : (n < 600) ? 1 : 2;
         srst  = (phase == 2) && ($urandom_range(0, 39) == 0);
         hold  = (phase != 0) && ($urandom_range(0, 9) < 2);
         for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
               acc[i]       = 1'b0;
               req_valid[i] = (phase == 0) ? 1'b1 : 1'($urandom_range(0, 1));
               new_req(i);
            end else if (!req_valid[i]) begin
               if (phase == 0 || $urandom_range(0, 3) == 0) begin
                  req_valid[i] = 1'b1;
                  new_req(i);
               end
            end
         end
         @(posedge clk);
         #1;
      end
      req_valid = '0;
      hold      = 1'b0;
      srst      = 1'b0;
      repeat (LAT + 3) begin
         @(posedge clk);
         #1;
      end
      chk("drain", 64'(sb.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
